// File: rtl/uart_rx_core.sv
// UART 8N1 receive engine with 16x oversampling and a valid/ready byte interface.
// Define UART_PARITY_EN to add an even-parity bit after the data bits (11-bit frames).
module uart_rx_core #(
  parameter int DIV_2400  = 2604,
  parameter int DIV_4800  = 1302,
  parameter int DIV_9600  = 651,
  parameter int DIV_19200 = 326,
  parameter int DIV_W     = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] baud_sel,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       busy
);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t state_reg, state_next;

  logic             rx_meta_reg;
  logic             rx_s_reg;
  logic [DIV_W-1:0] div_m1_reg;
  logic [DIV_W-1:0] sel_div_m1;
  logic [DIV_W-1:0] presc_reg;
  logic [3:0]       os_cnt_reg;
  logic [2:0]       bit_cnt_reg;
  logic [7:0]       shreg_reg;
  logic             armed_reg;
  logic [7:0]       rx_data_reg;
  logic             rx_valid_reg;
  logic             frame_err_reg;
  logic             overrun_reg;
  logic             tick;

  // Control strobes decoded by the FSM for the datapath below.
  logic start_det;
  logic go_data;
  logic sample_data;
  logic stop_good;
  logic stop_bad;
  logic deliver;

  always_comb begin
    sel_div_m1 = '0;
    case (baud_sel)
      2'b00:   sel_div_m1 = DIV_W'(DIV_2400 - 1);
      2'b01:   sel_div_m1 = DIV_W'(DIV_4800 - 1);
      2'b10:   sel_div_m1 = DIV_W'(DIV_9600 - 1);
      default: sel_div_m1 = DIV_W'(DIV_19200 - 1);
    endcase
  end

  assign tick = (presc_reg == div_m1_reg);

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

`ifdef UART_PARITY_EN
  logic sample_par;
`endif

  always_comb begin
    state_next  = state_reg;
    start_det   = 1'b0;
    go_data     = 1'b0;
    sample_data = 1'b0;
    stop_good   = 1'b0;
    stop_bad    = 1'b0;
`ifdef UART_PARITY_EN
    sample_par  = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        // After a bad stop the line must return high before a new start is accepted.
        if (armed_reg && !rx_s_reg) begin
          state_next = START;
          start_det  = 1'b1;
        end
      end
      START: begin
        if (tick && os_cnt_reg == 4'd7) begin
          if (!rx_s_reg) begin
            state_next = DATA;
            go_data    = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (tick && os_cnt_reg == 4'd15) begin
          sample_data = 1'b1;
          if (bit_cnt_reg == 3'd7) begin
`ifdef UART_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (tick && os_cnt_reg == 4'd15) begin
          sample_par = 1'b1;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        // Leave at mid-stop so a back-to-back start bit is not missed.
        if (tick && os_cnt_reg == 4'd15) begin
          state_next = IDLE;
          if (rx_s_reg) stop_good = 1'b1;
          else          stop_bad  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign deliver = stop_good && (!rx_valid_reg || rx_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_reg   <= 1'b1;
      rx_s_reg      <= 1'b1;
      div_m1_reg    <= '0;
      presc_reg     <= '0;
      os_cnt_reg    <= '0;
      bit_cnt_reg   <= '0;
      shreg_reg     <= '0;
      armed_reg     <= 1'b1;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;

      if (start_det) div_m1_reg <= sel_div_m1;

      if (start_det || state_reg == IDLE) presc_reg <= '0;
      else if (tick)                      presc_reg <= '0;
      else                                presc_reg <= presc_reg + 1'b1;

      // os_cnt wraps 15 -> 0 naturally, so each data bit spans exactly 16 ticks.
      if (start_det || go_data)             os_cnt_reg <= '0;
      else if (tick && state_reg != IDLE)   os_cnt_reg <= os_cnt_reg + 1'b1;

      if (go_data)          bit_cnt_reg <= '0;
      else if (sample_data) bit_cnt_reg <= bit_cnt_reg + 1'b1;

      if (sample_data) shreg_reg <= {rx_s_reg, shreg_reg[7:1]};

      if (stop_bad)                          armed_reg <= 1'b0;
      else if (state_reg == IDLE && rx_s_reg) armed_reg <= 1'b1;

      if (deliver) begin
        rx_data_reg  <= shreg_reg;
        rx_valid_reg <= 1'b1;
      end else if (rx_valid_reg && rx_ready) begin
        rx_valid_reg <= 1'b0;
      end

      frame_err_reg <= stop_bad;
      overrun_reg   <= stop_good && rx_valid_reg && !rx_ready;
    end
  end

`ifdef UART_PARITY_EN
  logic parity_err_reg;

  always_ff @(posedge clk) begin
    if (reset) parity_err_reg <= 1'b0;
    else       parity_err_reg <= sample_par && (rx_s_reg != ^shreg_reg);
  end

  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core, run with reduced divisors so every baud rate fits a short sim.
// Define UART_PARITY_EN on both files to exercise the parity section.
module tb_uart_rx_core;

  localparam int D2400  = 40;
  localparam int D4800  = 20;
  localparam int D9600  = 10;
  localparam int D19200 = 5;
`ifdef UART_PARITY_EN
  localparam int FRAME_TICKS = 8 + 9*16 + 16;
`else
  localparam int FRAME_TICKS = 8 + 8*16 + 16;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] baud_sel = 2'b10;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;
  logic       busy;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int fall_cyc = 0;

  // Monitor: counts high cycles of each pulse output and records each rx_valid rise.
  int vh_cnt = 0, fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, rises = 0, rise_cyc = 0;
  logic [7:0] rise_data = 8'h00;
  logic valid_prev = 1'b0;

  int s_vh, s_fe, s_ov, s_pe, s_rises, lat;

  uart_rx_core #(
    .DIV_2400 (D2400),
    .DIV_4800 (D4800),
    .DIV_9600 (D9600),
    .DIV_19200(D19200),
    .DIV_W    (12)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .baud_sel  (baud_sel),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) vh_cnt <= vh_cnt + 1;
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun) ov_cnt <= ov_cnt + 1;
    if (parity_err) pe_cnt <= pe_cnt + 1;
    if (rx_valid && !valid_prev) begin
      rises     <= rises + 1;
      rise_cyc  <= cyc;
      rise_data <= rx_data;
    end
    valid_prev <= rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic snap();
    s_vh = vh_cnt; s_fe = fe_cnt; s_ov = ov_cnt; s_pe = pe_cnt; s_rises = rises;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame LSB first; rx is left at the stop level afterwards.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop_bit, input int d);
    @(posedge clk); #1;
    rx = 1'b0;
    fall_cyc = cyc;
    for (int i = 0; i < 8; i++) begin
      wait_cyc(16*d);
      rx = b[i];
    end
`ifdef UART_PARITY_EN
    wait_cyc(16*d);
    rx = par;
`else
    if (par) begin end
`endif
    wait_cyc(16*d);
    rx = stop_bit;
    wait_cyc(16*d);
    $display("frame 0x%02h stop=%0b sent at cycle %0d", b, stop_bit, fall_cyc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish (passed %0d of %0d so far)", passed, total);
    $fatal(1);
  end

  initial begin
    // Reset state
    wait_cyc(3);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    check("reset_parity_err", parity_err, 1'b0);
    check("reset_busy", busy, 1'b0);
    reset = 1'b0;
    wait_cyc(10);

    // 9600: 0xA5, host always ready -> one-cycle rx_valid, exact latency
    baud_sel = 2'b10; rx_ready = 1'b1; snap();
    send_frame(8'hA5, ^8'hA5, 1'b1, D9600);
    wait_cyc(5);
    lat = rise_cyc - fall_cyc;
    check("a5_rises", rises - s_rises, 1);
    check("a5_data", rise_data, 8'hA5);
    check("a5_latency", (lat >= 3 + FRAME_TICKS*D9600 - 2) && (lat <= 3 + FRAME_TICKS*D9600 + 2), 1'b1);
    check("a5_valid_cycles", vh_cnt - s_vh, 1);
    check("a5_frame_err", fe_cnt - s_fe, 0);
    check("a5_busy", busy, 1'b0);

    // 19200: 0x00 then 0xFF back-to-back, host not ready -> overrun on the second
    baud_sel = 2'b11; rx_ready = 1'b0; snap();
    send_frame(8'h00, 1'b0, 1'b1, D19200);
    send_frame(8'hFF, 1'b0, 1'b1, D19200);
    wait_cyc(5);
    check("b2b_rises", rises - s_rises, 1);
    check("b2b_data_kept", rx_data, 8'h00);
    check("b2b_valid_held", rx_valid, 1'b1);
    check("b2b_overrun", ov_cnt - s_ov, 1);
    check("b2b_frame_err", fe_cnt - s_fe, 0);

    // 9600: reset pulse in the middle of the data bits, then a clean 0x81
    baud_sel = 2'b10;
    @(posedge clk); #1;
    rx = 1'b0; wait_cyc(16*D9600);
    rx = 1'b1; wait_cyc(16*D9600);
    rx = 1'b0; wait_cyc(24*D9600);
    check("mid_busy", busy, 1'b1);
    reset = 1'b1;
    wait_cyc(1);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    reset = 1'b0; rx = 1'b1; rx_ready = 1'b1;
    wait_cyc(200);
    snap();
    send_frame(8'h81, ^8'h81, 1'b1, D9600);
    wait_cyc(5);
    check("r81_rises", rises - s_rises, 1);
    check("r81_data", rise_data, 8'h81);
    check("r81_busy", busy, 1'b0);

    // 4800: 60-clock low glitch (half a bit is 160 clocks here)
    baud_sel = 2'b01; snap();
    @(posedge clk); #1;
    rx = 1'b0; wait_cyc(30);
    check("glitch_busy_start", busy, 1'b1);
    wait_cyc(30);
    rx = 1'b1; wait_cyc(300);
    check("glitch_rises", rises - s_rises, 0);
    check("glitch_frame_err", fe_cnt - s_fe, 0);
    check("glitch_busy_end", busy, 1'b0);

    // 2400: 0x3C with a low stop bit, line stays low, then a valid 0x55
    baud_sel = 2'b00; snap();
    send_frame(8'h3C, ^8'h3C, 1'b0, D2400);
    wait_cyc(2000);
    check("ferr_pulse", fe_cnt - s_fe, 1);
    check("ferr_rises", rises - s_rises, 0);
    check("ferr_valid", rx_valid, 1'b0);
    check("ferr_stuck_low_idle", busy, 1'b0);
    rx = 1'b1;
    wait_cyc(100);
    send_frame(8'h55, ^8'h55, 1'b1, D2400);
    wait_cyc(5);
    check("r55_rises", rises - s_rises, 1);
    check("r55_data", rise_data, 8'h55);
    check("r55_no_new_ferr", fe_cnt - s_fe, 1);

`ifdef UART_PARITY_EN
    // 9600: 0x07 with wrong parity 0, then with correct parity 1
    baud_sel = 2'b10; rx_ready = 1'b0; snap();
    send_frame(8'h07, 1'b0, 1'b1, D9600);
    wait_cyc(5);
    check("par_bad_pulse", pe_cnt - s_pe, 1);
    check("par_bad_data", rx_data, 8'h07);
    check("par_bad_valid", rx_valid, 1'b1);
    rx_ready = 1'b1;
    wait_cyc(5);
    snap();
    send_frame(8'h07, 1'b1, 1'b1, D9600);
    wait_cyc(5);
    check("par_good_pulse", pe_cnt - s_pe, 0);
    check("par_good_data", rise_data, 8'h07);
    check("par_good_rises", rises - s_rises, 1);
`else
    check("no_parity_err_ever", pe_cnt, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
